spi_master: RTL and testbench

- Single-channel SPI master for an 8-bit full-duplex exchange, SPI mode 3 (CPOL=1, CPHA=1), MSB first.
- A transfer starts when the host raises ready_send. The block drives ss, sclk and mosi, samples miso, and presents the received byte on data_out.
- Sits between a host-side byte interface and an off-chip SPI slave.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_clk_div.sv | 39 +++
 rtl/spi_master.sv | 137 +++++++++++++
 tb/tb_spi_master.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master.
// Holds the FSM state encoding and default sizing.
package spi_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CLK_DIV    = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_HOLD
    } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter for the SPI clock.
// Pulses tick_o once every CLK_DIV cycles while not cleared.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Tick on the last count of a half-period, then wrap.
    always_comb begin
        tick_o = 1'b0;
        cnt_d  = cnt_q + CW'(1);
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            tick_o = 1'b1;
            cnt_d  = '0;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode 3 master, MSB first, full duplex.
// FSM, shift registers and bit counter; all outputs registered.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CLK_DIV    = DEF_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miso,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  ready_send,
    output logic                  mosi,
    output logic                  sclk,
    output logic                  ss,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] NBITS = BW'(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  ss_q, ss_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  tick;
    logic                  div_clr;

    // Divider is held cleared in IDLE so SETUP starts a full half-period.
    assign div_clr = (state_q == S_IDLE);

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .clr_i (div_clr),
        .tick_o(tick)
    );

    assign mosi     = mosi_q;
    assign sclk     = sclk_q;
    assign ss       = ss_q;
    assign data_out = dout_q;

    // Next-state and registered-output logic for the transfer sequence.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        bit_d   = bit_q;
        ss_d    = ss_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        unique case (state_q)
            S_IDLE: begin
                ss_d   = 1'b0;
                sclk_d = 1'b1;
                if (ready_send) begin
                    tx_d    = data_in;
                    rx_d    = '0;
                    bit_d   = '0;
                    ss_d    = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b0;
                    mosi_d  = tx_q[DATA_WIDTH-1];
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[DATA_WIDTH-2:0], miso};
                    bit_d   = bit_q + BW'(1);
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (tick) begin
                    if (bit_q < NBITS) begin
                        tx_d    = tx_q << 1;
                        sclk_d  = 1'b0;
                        mosi_d  = tx_q[DATA_WIDTH-2];
                        state_d = S_LOW;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    ss_d    = 1'b0;
                    dout_d  = rx_q;
                    mosi_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            bit_q   <= '0;
            ss_q    <= 1'b0;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            bit_q   <= bit_d;
            ss_q    <= ss_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master with a mode-3 slave model.
// Stimulus pushes expected bytes; a monitor checks each ss fall.
module tb_spi_master;

    localparam int DW = 8;
    localparam int CD = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          miso = 1'b0;
    logic          ready_send = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          mosi;
    logic          sclk;
    logic          ss;
    logic [DW-1:0] data_out;

    spi_master #(
        .DATA_WIDTH(DW),
        .CLK_DIV   (CD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .miso      (miso),
        .data_in   (data_in),
        .ready_send(ready_send),
        .mosi      (mosi),
        .sclk      (sclk),
        .ss        (ss),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] rx;
        bit            abort;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Slave: load byte at ss rise, present next bit after each sclk fall.
    logic [DW-1:0] slave_byte = '0;
    logic [DW-1:0] slave_q = '0;

    always @(posedge ss) slave_q = slave_byte;

    always @(negedge sclk) begin
        if (ss === 1'b1) begin
            miso    = slave_q[DW-1];
            slave_q = {slave_q[DW-2:0], 1'b0};
        end
    end

    // Cycle counter for measuring ss duration.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sample at negedge, detect edges, score on ss fall.
    bit            armed = 1'b0;
    logic          pss = 1'b0;
    logic          psclk = 1'b1;
    logic [DW-1:0] pdout = '0;
    int            t0 = 0;
    int            rises = 0;
    logic [DW-1:0] msh = '0;

    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            if (!pss && ss) begin
                t0    = cyc;
                rises = 0;
                msh   = '0;
            end
            if (ss && !psclk && sclk) begin
                rises++;
                msh = {msh[DW-2:0], mosi};
            end
            if (pss && !ss) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ss_fall: got none expected entry");
                end else begin
                    e = q.pop_front();
                    if (e.abort) begin
                        chk("abort_sclk", 32'(sclk), 32'd1);
                        chk("abort_dout", 32'(data_out), 32'd0);
                        chk("abort_mosi", 32'(mosi), 32'd0);
                    end else begin
                        chk("rx_data", 32'(data_out), 32'(e.rx));
                        chk("tx_mosi", 32'(msh), 32'(e.tx));
                        chk("rise_cnt", 32'(rises), 32'd8);
                        chk("ss_len", 32'(cyc - t0), 32'(18 * CD));
                    end
                end
            end else if (data_out !== pdout) begin
                chk("dout_hold", 32'(data_out), 32'(pdout));
            end
        end
        pss   = ss;
        psclk = sclk;
        pdout = data_out;
    end

    task automatic wait_ss(input logic v);
        int n;
        n = 0;
        while (ss !== v && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (ss !== v) begin
            checks++;
            failures++;
            $display("FAIL wait_ss: got 0x%0h expected 0x%0h", ss, v);
        end
    endtask

    task automatic start(input logic [DW-1:0] tx, input logic [DW-1:0] rx,
                         input bit ab);
        exp_t e;
        slave_byte = rx;
        data_in    = tx;
        ready_send = 1'b1;
        @(negedge clk);
        wait_ss(1'b1);
        ready_send = 1'b0;
        e.tx    = tx;
        e.rx    = rx;
        e.abort = ab;
        q.push_back(e);
    endtask

    task automatic xfer(input logic [DW-1:0] tx, input logic [DW-1:0] rx);
        start(tx, rx, 1'b0);
        wait_ss(1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int   bad;
        int   n;
        exp_t e;

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_ss", 32'(ss), 32'd0);
        chk("rst_sclk", 32'(sclk), 32'd1);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        rst   = 1'b0;
        armed = 1'b1;
        @(negedge clk);

        xfer(8'h13, 8'h37);

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (ss !== 1'b0 || sclk !== 1'b1) bad++;
        end
        chk("idle_quiet", 32'(bad), 32'd0);

        start(8'h13, 8'hE1, 1'b0);
        repeat (5) @(negedge clk);
        data_in = 8'hFF;
        wait_ss(1'b0);
        repeat (3) @(negedge clk);

        start(8'hC7, 8'h81, 1'b1);
        n = 0;
        while (rises < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach", 32'(rises >= 3), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ss", 32'(ss), 32'd0);
        repeat (3) @(negedge clk);

        xfer(8'h96, 8'h69);

        slave_byte = 8'hC3;
        data_in    = 8'hA5;
        ready_send = 1'b1;
        @(negedge clk);
        wait_ss(1'b1);
        e.tx = 8'hA5; e.rx = 8'hC3; e.abort = 1'b0;
        q.push_back(e);
        data_in    = 8'h5A;
        slave_byte = 8'h3C;
        wait_ss(1'b0);
        e.tx = 8'h5A; e.rx = 8'h3C; e.abort = 1'b0;
        q.push_back(e);
        n = 0;
        while (ss !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_restart", 32'(ss), 32'd1);
        chk("b2b_gap", 32'(n >= 1), 32'd1);
        ready_send = 1'b0;
        wait_ss(1'b0);
        repeat (3) @(negedge clk);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
